mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multicycle control unit driving the single-cycle MIPS datapath's control inputs, and the memory-side handshake owner for instruction fetch and data access.
- Holds the current instruction in an internal register (`ir`) and sequences FETCH/EXEC/MEM/WB.
- Advances the PC only through a one-cycle `pc_en` strobe, so memories with variable wait states are tolerated.
- A watchdog halts the core if a memory never responds.

Parameters:
- COUNT_W, 32: width of retired-instruction counter.
- TIMEOUT, 16: maximum wait cycles for imem_ready/dmem_ready before bus error (must be ≥1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- zero  in  1  ALU zero flag from datapath
- imem_rdata  in  32  instruction word from instruction memory
- imem_ready  in  1  fetch data valid this cycle
- dmem_ready  in  1  data access complete this cycle
- instruction  out  32  registered instruction (`ir`) to datapath
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write strobe, valid with dmem_req
- pc_en  out  1  one-cycle PC update enable
- rf_we  out  1  register file write enable
- sel_alu_b  out  1  0=rt register, 1=sign_imm
- sel_wa  out  2  0=rt, 1=rd, 2=r31
- sel_result  out  2  0=dmem rd, 1=alu_out, 2=pc+4
- sel_pc  out  2  0=pc+4, 1=branch, 2=jump, 3=result
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- illegal  out  1  sticky: unsupported opcode/funct seen
- bus_error  out  1  sticky: memory timeout
- retired  out  COUNT_W  count of completed instructions

Behaviour:

Reset (reset=0 at a clock edge):
- State→FETCH, `ir`=0, wait counter=0, retired=0, illegal=0, bus_error=0.
- All strobes (imem_req, dmem_req, dmem_we, pc_en, rf_we) are 0 while reset is low. Selects are 0 and alu_ctrl=0010.
- Reset mid-transaction aborts it with no PC or RF update.

Output timing:
- Strobes and selects are combinational from state, `ir` and zero.
- Outside the write/advance cycle: rf_we=0 and pc_en=0. Selects hold their decoded values from `ir` so datapath paths are stable.

FETCH:
- imem_req=1.
- On imem_ready=1: `ir`←imem_rdata, go to EXEC. The wait counter clears.
- Otherwise the wait counter increments. On reaching TIMEOUT: bus_error←1, go to HALT.

EXEC (exactly one cycle). Decode of `ir`:
- R-type (op 000000) add/sub/and/or/slt/nor (funct 100000/100010/100100/100101/101010/100111):
  - sel_alu_b=0, sel_wa=1, sel_result=1, alu_ctrl per funct.
  - rf_we=1, pc_en=1, sel_pc=0, go to FETCH.
- jr (funct 001000):
  - alu_ctrl=ADD (rt=$0 gives rs), sel_result=1, sel_pc=3.
  - rf_we=0, pc_en=1, go to FETCH.
- addi 001000 / slti 001010 / andi 001100 / ori 001101:
  - sel_alu_b=1, sel_wa=0, sel_result=1, alu_ctrl ADD/SLT/AND/OR.
  - rf_we=1, pc_en=1, go to FETCH.
  - Immediate is sign-extended for all four; this is the datapath's behaviour.
- beq 000100 / bne 000101:
  - alu_ctrl=SUB, sel_alu_b=0, pc_en=1.
  - sel_pc=1 if (beq and zero) or (bne and !zero), else 0.
  - Go to FETCH.
- j 000010: sel_pc=2, pc_en=1, go to FETCH.
- jal 000011:
  - sel_pc=2, sel_wa=2, sel_result=2, rf_we=1, pc_en=1.
  - Go to FETCH.
- lw 100011 / sw 101011: alu_ctrl=ADD, sel_alu_b=1, go to MEM, no strobes.
- Anything else: illegal←1, treated as NOP (pc_en=1, sel_pc=0), go to FETCH.

MEM:
- dmem_req=1, dmem_we=1 for sw. Address and data remain valid from the datapath.
- sw on dmem_ready: pc_en=1, go to FETCH.
- lw on dmem_ready: go to WB.
- Timeout behaves as in FETCH.

WB (lw only):
- sel_wa=0, sel_result=0, rf_we=1, pc_en=1.
- Go to FETCH.
- Memory rd must be held by memory until the next request.

HALT:
- All strobes are 0. The only exit is reset.

Counters:
- retired increments by 1 on every cycle where pc_en=1, wrapping at 2^COUNT_W.
- The wait counter resets on every state entry.
- A ready arriving in the same cycle the counter reaches TIMEOUT-1 is accepted, not a timeout.

Latency (with zero-wait memory):
- ALU/branch/jump instructions: 2 cycles.
- sw: 3 cycles.
- lw: 4 cycles.
- pc_en and rf_we are always coincident for writing instructions, so PC and RF update on the same edge.

Test Plan:
- Reset low 2 cycles, then high with imem_ready=1 and imem_rdata=0x20080005 (addi $8,$0,5):
  - FETCH→EXEC.
  - In EXEC: sel_alu_b=1, sel_wa=0, sel_result=1, alu_ctrl=0010, rf_we=1, pc_en=1.
  - retired=1.
- lw 0x8C090000 with dmem_ready delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we=0.
  - Then WB: rf_we=1, sel_result=0, pc_en=1.
  - Total 7 cycles.
- sw 0xAC090004, dmem_ready immediate: dmem_req=1, dmem_we=1, pc_en=1 in MEM, rf_we=0 throughout.
- beq 0x11090003:
  - zero=1 → sel_pc=1.
  - zero=0 → sel_pc=0.
  - pc_en=1 in both cases.
  - Repeat with bne: inverted results.
- jal 0x0C000010: sel_pc=2, sel_wa=2, sel_result=2, rf_we=1.
- jr 0x03E00008: sel_pc=3, sel_result=1, rf_we=0.
- Error cases:
  - Opcode 0x3F: illegal=1 sticky, pc_en=1.
  - imem_ready held 0 for 16 cycles: bus_error=1, HALT with strobes 0.
  - Reset clears both flags.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: owns the instruction register, sequences FETCH/EXEC/MEM/WB,
// and drives datapath selects plus the instruction/data memory handshakes with a timeout watchdog.
module mips_mc_control #(
  parameter int COUNT_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zero,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic [31:0]        instruction,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               pc_en,
  output logic               rf_we,
  output logic               sel_alu_b,
  output logic [1:0]         sel_wa,
  output logic [1:0]         sel_result,
  output logic [1:0]         sel_pc,
  output logic [3:0]         alu_ctrl,
  output logic               illegal,
  output logic               bus_error,
  output logic [COUNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_JR      = 4'd1,
    C_IMM     = 4'd2,
    C_BRANCH  = 4'd3,
    C_J       = 4'd4,
    C_JAL     = 4'd5,
    C_LOAD    = 4'd6,
    C_STORE   = 4'd7,
    C_ILLEGAL = 4'd8
  } iclass_t;

  state_t              state_r, state_s;
  logic [31:0]         ir_r;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
  logic                illegal_r, bus_error_r;
  logic [COUNT_W-1:0]  retired_r;

  iclass_t             cls_s;
  logic [5:0]          op_s, funct_s;
  logic [3:0]          dec_alu_s;
  logic                dec_alu_b_s;
  logic [1:0]          dec_wa_s, dec_result_s, dec_pc_s;

  logic                imem_req_s, dmem_req_s, dmem_we_s, pc_en_s, rf_we_s;
  logic                load_ir_s, wait_inc_s, set_illegal_s, set_bus_err_s;

  assign op_s    = ir_r[31:26];
  assign funct_s = ir_r[5:0];

  // Instruction decode: selects depend only on ir and zero so datapath paths stay stable in every state
  always_comb begin
    cls_s        = C_ILLEGAL;
    dec_alu_s    = ALU_ADD;
    dec_alu_b_s  = 1'b0;
    dec_wa_s     = 2'd0;
    dec_result_s = 2'd0;
    dec_pc_s     = 2'd0;
    case (op_s)
      6'b000000: begin
        dec_wa_s     = 2'd1;
        dec_result_s = 2'd1;
        case (funct_s)
          6'b100000: begin cls_s = C_RTYPE; dec_alu_s = ALU_ADD; end
          6'b100010: begin cls_s = C_RTYPE; dec_alu_s = ALU_SUB; end
          6'b100100: begin cls_s = C_RTYPE; dec_alu_s = ALU_AND; end
          6'b100101: begin cls_s = C_RTYPE; dec_alu_s = ALU_OR;  end
          6'b101010: begin cls_s = C_RTYPE; dec_alu_s = ALU_SLT; end
          6'b100111: begin cls_s = C_RTYPE; dec_alu_s = ALU_NOR; end
          6'b001000: begin
            cls_s    = C_JR;
            dec_wa_s = 2'd0;
            dec_pc_s = 2'd3;
          end
          default: begin
            cls_s        = C_ILLEGAL;
            dec_wa_s     = 2'd0;
            dec_result_s = 2'd0;
          end
        endcase
      end
      6'b001000: begin cls_s = C_IMM; dec_alu_b_s = 1'b1; dec_result_s = 2'd1; dec_alu_s = ALU_ADD; end
      6'b001010: begin cls_s = C_IMM; dec_alu_b_s = 1'b1; dec_result_s = 2'd1; dec_alu_s = ALU_SLT; end
      6'b001100: begin cls_s = C_IMM; dec_alu_b_s = 1'b1; dec_result_s = 2'd1; dec_alu_s = ALU_AND; end
      6'b001101: begin cls_s = C_IMM; dec_alu_b_s = 1'b1; dec_result_s = 2'd1; dec_alu_s = ALU_OR;  end
      6'b000100: begin
        cls_s     = C_BRANCH;
        dec_alu_s = ALU_SUB;
        dec_pc_s  = zero ? 2'd1 : 2'd0;
      end
      6'b000101: begin
        cls_s     = C_BRANCH;
        dec_alu_s = ALU_SUB;
        dec_pc_s  = zero ? 2'd0 : 2'd1;
      end
      6'b000010: begin cls_s = C_J; dec_pc_s = 2'd2; end
      6'b000011: begin
        cls_s        = C_JAL;
        dec_pc_s     = 2'd2;
        dec_wa_s     = 2'd2;
        dec_result_s = 2'd2;
      end
      6'b100011: begin cls_s = C_LOAD;  dec_alu_b_s = 1'b1; end
      6'b101011: begin cls_s = C_STORE; dec_alu_b_s = 1'b1; end
      default:   cls_s = C_ILLEGAL;
    endcase
  end

  // Next-state and strobe generation; the wait counter only survives while a state keeps waiting
  always_comb begin
    state_s       = state_r;
    imem_req_s    = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    pc_en_s       = 1'b0;
    rf_we_s       = 1'b0;
    load_ir_s     = 1'b0;
    wait_inc_s    = 1'b0;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          load_ir_s = 1'b1;
          state_s   = S_EXEC;
        end else if (wait_cnt_r == WAIT_LAST) begin
          set_bus_err_s = 1'b1;
          state_s       = S_HALT;
        end else begin
          wait_inc_s = 1'b1;
        end
      end
      S_EXEC: begin
        case (cls_s)
          C_LOAD, C_STORE: state_s = S_MEM;
          C_RTYPE, C_IMM, C_JAL: begin
            rf_we_s = 1'b1;
            pc_en_s = 1'b1;
            state_s = S_FETCH;
          end
          C_ILLEGAL: begin
            set_illegal_s = 1'b1;
            pc_en_s       = 1'b1;
            state_s       = S_FETCH;
          end
          default: begin
            pc_en_s = 1'b1;
            state_s = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (cls_s == C_STORE);
        if (dmem_ready) begin
          pc_en_s = (cls_s == C_STORE);
          state_s = (cls_s == C_STORE) ? S_FETCH : S_WB;
        end else if (wait_cnt_r == WAIT_LAST) begin
          set_bus_err_s = 1'b1;
          state_s       = S_HALT;
        end else begin
          wait_inc_s = 1'b1;
        end
      end
      S_WB: begin
        rf_we_s = 1'b1;
        pc_en_s = 1'b1;
        state_s = S_FETCH;
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_FETCH;
    endcase
  end

  assign wait_cnt_s = wait_inc_s ? (wait_cnt_r + WAIT_W'(1)) : {WAIT_W{1'b0}};

  // Sequential state: FSM, instruction register, watchdog, sticky flags and retire counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= S_FETCH;
      ir_r        <= 32'd0;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      illegal_r   <= 1'b0;
      bus_error_r <= 1'b0;
      retired_r   <= {COUNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      ir_r       <= load_ir_s ? imem_rdata : ir_r;
      illegal_r  <= illegal_r | set_illegal_s;
      bus_error_r <= bus_error_r | set_bus_err_s;
      retired_r  <= pc_en_s ? (retired_r + COUNT_W'(1)) : retired_r;
    end
  end

  // Reset forces strobes low and selects to their idle values even before the first edge
  assign imem_req    = reset & imem_req_s;
  assign dmem_req    = reset & dmem_req_s;
  assign dmem_we     = reset & dmem_we_s;
  assign pc_en       = reset & pc_en_s;
  assign rf_we       = reset & rf_we_s;
  assign sel_alu_b   = reset & dec_alu_b_s;
  assign sel_wa      = reset ? dec_wa_s     : 2'd0;
  assign sel_result  = reset ? dec_result_s : 2'd0;
  assign sel_pc      = reset ? dec_pc_s     : 2'd0;
  assign alu_ctrl    = reset ? dec_alu_s    : ALU_ADD;
  assign instruction = ir_r;
  assign illegal     = illegal_r;
  assign bus_error   = bus_error_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class, memory wait states,
// sticky error flags and the fetch watchdog, with hand-computed expectations.
module tb_mips_mc_control;

  logic        clock;
  logic        reset;
  logic        zero;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_ready;
  logic [31:0] instruction;
  logic        imem_req, dmem_req, dmem_we, pc_en, rf_we, sel_alu_b;
  logic [1:0]  sel_wa, sel_result, sel_pc;
  logic [3:0]  alu_ctrl;
  logic        illegal, bus_error;
  logic [31:0] retired;

  int total;
  int bad;

  mips_mc_control #(.COUNT_W(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .zero(zero),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .instruction(instruction), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .pc_en(pc_en), .rf_we(rf_we), .sel_alu_b(sel_alu_b),
    .sel_wa(sel_wa), .sel_result(sel_result), .sel_pc(sel_pc),
    .alu_ctrl(alu_ctrl), .illegal(illegal), .bus_error(bus_error),
    .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Present an instruction with zero-wait fetch; returns positioned in EXEC
  task automatic fetch(input logic [31:0] insn);
    imem_rdata = insn;
    imem_ready = 1'b1;
    #1;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    tick();
    imem_ready = 1'b0;
    #1;
    check("ir_load", instruction, insn);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0; zero = 1'b0; imem_rdata = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick();
    tick();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_alu", {28'd0, alu_ctrl}, 32'h2);
    check("rst_sels", {26'd0, sel_wa, sel_result, sel_pc}, 32'd0);
    check("rst_ir", instruction, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_flags", {30'd0, illegal, bus_error}, 32'd0);

    // addi $8,$0,5
    reset = 1'b1;
    fetch(32'h20080005);
    check("addi_alu_b", {31'd0, sel_alu_b}, 32'd1);
    check("addi_wa", {30'd0, sel_wa}, 32'd0);
    check("addi_res", {30'd0, sel_result}, 32'd1);
    check("addi_alu", {28'd0, alu_ctrl}, 32'h2);
    check("addi_we_pc", {30'd0, rf_we, pc_en}, 32'h3);
    tick();
    check("addi_retired", retired, 32'd1);
    check("fetch_idle_strobes", {30'd0, rf_we, pc_en}, 32'd0);

    // lw with dmem_ready on the fourth MEM cycle
    fetch(32'h8C090000);
    check("lw_exec_strobes", {29'd0, dmem_req, rf_we, pc_en}, 32'd0);
    check("lw_exec_alu_b", {31'd0, sel_alu_b}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      check("lw_mem_req_we", {30'd0, dmem_req, dmem_we}, 32'h2);
      check("lw_mem_no_wr", {30'd0, rf_we, pc_en}, 32'd0);
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    check("lw_wb_we_pc", {29'd0, dmem_req, rf_we, pc_en}, 32'h3);
    check("lw_wb_res", {30'd0, sel_result}, 32'd0);
    check("lw_wb_wa", {30'd0, sel_wa}, 32'd0);
    tick();
    check("lw_retired", retired, 32'd2);
    check("lw_back_fetch", {31'd0, imem_req}, 32'd1);

    // sw with immediate ready
    fetch(32'hAC090004);
    check("sw_exec_strobes", {29'd0, dmem_req, rf_we, pc_en}, 32'd0);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("sw_mem", {28'd0, dmem_req, dmem_we, pc_en, rf_we}, 32'hE);
    tick();
    dmem_ready = 1'b0;
    check("sw_retired", retired, 32'd3);

    // beq then bne, each with zero=1 and zero=0
    fetch(32'h11090003);
    zero = 1'b1; #1;
    check("beq_z1_pc", {30'd0, sel_pc}, 32'd1);
    check("beq_pc_en", {30'd0, pc_en, rf_we}, 32'h2);
    check("beq_alu", {28'd0, alu_ctrl}, 32'h6);
    zero = 1'b0; #1;
    check("beq_z0_pc", {30'd0, sel_pc}, 32'd0);
    check("beq_z0_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    fetch(32'h15090003);
    zero = 1'b1; #1;
    check("bne_z1_pc", {30'd0, sel_pc}, 32'd0);
    zero = 1'b0; #1;
    check("bne_z0_pc", {30'd0, sel_pc}, 32'd1);
    check("bne_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    check("br_retired", retired, 32'd5);

    // jal and jr
    fetch(32'h0C000010);
    check("jal_sels", {26'd0, sel_pc, sel_wa, sel_result}, 32'h2A);
    check("jal_we_pc", {30'd0, rf_we, pc_en}, 32'h3);
    tick();
    fetch(32'h03E00008);
    check("jr_pc", {30'd0, sel_pc}, 32'd3);
    check("jr_res", {30'd0, sel_result}, 32'd1);
    check("jr_we_pc", {30'd0, rf_we, pc_en}, 32'h1);
    tick();
    check("jump_retired", retired, 32'd7);

    // R-type sub and slt, immediate ori
    fetch(32'h00221822);
    check("sub_alu", {28'd0, alu_ctrl}, 32'h6);
    check("sub_wa_res", {28'd0, sel_wa, sel_result}, 32'h5);
    check("sub_we_pc", {29'd0, sel_alu_b, rf_we, pc_en}, 32'h3);
    tick();
    fetch(32'h0022182A);
    check("slt_alu", {28'd0, alu_ctrl}, 32'h7);
    tick();
    fetch(32'h34080F0F);
    check("ori_alu", {28'd0, alu_ctrl}, 32'h1);
    check("ori_alu_b", {31'd0, sel_alu_b}, 32'd1);
    tick();
    check("alu_retired", retired, 32'd10);

    // Illegal opcode 0x3F behaves as NOP and sets a sticky flag
    fetch(32'hFC000000);
    check("ill_pc_en", {29'd0, sel_pc, pc_en}, 32'h1);
    check("ill_no_we", {31'd0, rf_we}, 32'd0);
    tick();
    check("ill_flag", {31'd0, illegal}, 32'd1);
    fetch(32'h08000000);
    check("j_pc", {30'd0, sel_pc}, 32'd2);
    tick();
    check("ill_sticky", {31'd0, illegal}, 32'd1);
    check("ill_retired", retired, 32'd12);

    // Ready on the last allowed wait cycle is accepted
    imem_ready = 1'b0;
    imem_rdata = 32'h20080005;
    for (int i = 0; i < 15; i++) tick();
    check("edge_no_err", {31'd0, bus_error}, 32'd0);
    fetch(32'h20080005);
    check("edge_exec_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    check("edge_retired", retired, 32'd13);

    // Fetch never answered: watchdog halts after 16 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_err", {30'd0, bus_error, imem_req}, 32'h1);
    tick();
    check("to_err", {31'd0, bus_error}, 32'd1);
    check("halt_strobes", {27'd0, imem_req, dmem_req, dmem_we, pc_en, rf_we}, 32'd0);
    imem_ready = 1'b1;
    tick();
    tick();
    check("halt_stays", {31'd0, imem_req}, 32'd0);
    check("halt_retired", retired, 32'd13);

    // Reset clears sticky flags and counter
    reset = 1'b0;
    tick();
    check("rst2_flags", {30'd0, illegal, bus_error}, 32'd0);
    check("rst2_retired", retired, 32'd0);
    check("rst2_ir", instruction, 32'd0);
    reset = 1'b1;
    imem_ready = 1'b0;
    #1;
    check("rst2_fetch", {31'd0, imem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
